// File: rtl/multi_arbiter_if.sv
// multi_arbiter_if: handshake and data bundle between two operand producers,
// one result consumer and the multi_arbiter.
//   slave  : the arbiter side
//   master : the producer/consumer side
interface multi_arbiter_if;
   logic        req0_valid;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        req1_ready;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_id;
   logic        res_ready;
   logic        busy;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id,
      input  busy
   );
endinterface

// File: rtl/multi_arbiter.sv
// multi_arbiter: shares one combinational signed 16x16 multiplier (multi_top)
// between two requesters with round-robin arbitration. Operands are held
// stable on the multiplier for CALC_CYCLES clocks (multicycle path), then the
// product is captured, tagged with the requester id and held until accepted.
// Optional feature macro: MULTI_ARB_STATS_EN adds saturating per-requester
// accepted-transfer counters on ports grant_cnt0 / grant_cnt1.

module multi_top (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] out
);
   logic signed [31:0] a_ext_s;
   logic signed [31:0] b_ext_s;

   // Sign-extend both operands; the low 32 bits of the product are exact.
   always_comb begin
      a_ext_s = {{16{a[15]}}, a};
      b_ext_s = {{16{b[15]}}, b};
      out     = a_ext_s * b_ext_s;
   end
endmodule

module multi_arbiter #(
   parameter int CALC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   multi_arbiter_if.slave   bus
`ifdef MULTI_ARB_STATS_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
`endif
);

   generate
      if ((CALC_CYCLES < 1) || (CALC_CYCLES > 15)) begin : g_bad_calc_cycles
         $error("multi_arbiter: CALC_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

   logic [1:0]  state_q,     state_d;
   logic        rr_last_q,   rr_last_d;
   logic [15:0] op_a_q,      op_a_d;
   logic [15:0] op_b_q,      op_b_d;
   logic        id_q,        id_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic        res_valid_q, res_valid_d;
   logic [31:0] res_data_q,  res_data_d;
   logic        res_id_q,    res_id_d;
   logic        busy_q,      busy_d;

   logic        gnt_valid_s;
   logic        gnt_id_s;
   logic [15:0] gnt_a_s;
   logic [15:0] gnt_b_s;
   logic [31:0] mul_out_s;

   // The multiplier only ever sees the registered operands, so its inputs are
   // stable for the whole CALC window.
   multi_top u_multi_top (
      .a   (op_a_q),
      .b   (op_b_q),
      .out (mul_out_s)
   );

   // Round-robin grant, only offered in IDLE; on contention the requester
   // that did not win last time is chosen.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      if (state_q == ST_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = ~rr_last_q;
         end else if (bus.req0_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b0;
         end else if (bus.req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b1;
         end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
         end
      end else begin
         gnt_valid_s = 1'b0;
         gnt_id_s    = 1'b0;
      end
   end

   // Operand select for the granted requester.
   always_comb begin
      if (gnt_id_s) begin
         gnt_a_s = bus.req1_a;
         gnt_b_s = bus.req1_b;
      end else begin
         gnt_a_s = bus.req0_a;
         gnt_b_s = bus.req0_b;
      end
   end

   // Ready is the grant itself; gated by rst_n so it reads 0 while in reset.
   assign bus.req0_ready = rst_n & gnt_valid_s & ~gnt_id_s;
   assign bus.req1_ready = rst_n & gnt_valid_s &  gnt_id_s;

   // FSM next-state: IDLE accepts, CALC counts down the multicycle window,
   // HOLD presents the result until the consumer takes it.
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid_s) begin
               op_a_d    = gnt_a_s;
               op_b_d    = gnt_b_s;
               id_d      = gnt_id_s;
               rr_last_d = gnt_id_s;
               cnt_d     = CNT_INIT;
               state_d   = ST_CALC;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_q != 4'd0) begin
               cnt_d       = cnt_q - 4'd1;
            end else begin
               res_data_d  = mul_out_s;
               res_id_d    = id_q;
               res_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_HOLD;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CALC) || (state_d == ST_HOLD);
   end

   // State and output registers; async reset discards any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_last_q   <= 1'b1;
         op_a_q      <= 16'd0;
         op_b_q      <= 16'd0;
         id_q        <= 1'b0;
         cnt_q       <= 4'd0;
         res_valid_q <= 1'b0;
         res_data_q  <= 32'd0;
         res_id_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
   assign bus.busy      = busy_q;

`ifdef MULTI_ARB_STATS_EN
   logic [15:0] grant_cnt0_q, grant_cnt0_d;
   logic [15:0] grant_cnt1_q, grant_cnt1_d;

   // Saturating count of accepted transfers per requester.
   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (gnt_valid_s && !gnt_id_s && (grant_cnt0_q != 16'hFFFF)) begin
         grant_cnt0_d = grant_cnt0_q + 16'd1;
      end else begin
         grant_cnt0_d = grant_cnt0_q;
      end
      if (gnt_valid_s && gnt_id_s && (grant_cnt1_q != 16'hFFFF)) begin
         grant_cnt1_d = grant_cnt1_q + 16'd1;
      end else begin
         grant_cnt1_d = grant_cnt1_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q <= 16'd0;
         grant_cnt1_q <= 16'd0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_multi_arbiter.sv
// tb_multi_arbiter: directed and random stimulus on both requester ports;
// a scoreboard queue is filled on every accepted transfer and a separate
// monitor pops and compares whenever a result is handed over.
module tb_multi_arbiter;
   localparam int CALC = 2;
   localparam int TMO  = 200;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   multi_arbiter_if bus ();

`ifdef MULTI_ARB_STATS_EN
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;
`endif

   multi_arbiter #(.CALC_CYCLES(CALC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MULTI_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic        grant_log[$];
   logic [31:0] pend_exp [2];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          n_acc = 0;
   int          n_res = 0;
   int          res_mode = 0;   // 0: always ready, 1: random, 2: held low

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
      int ia;
      int ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      return 32'(ia * ib);
   endfunction

   task automatic record_accept(input logic id);
      exp_t e;
      e.id   = id;
      e.data = pend_exp[id];
      e.cyc  = cyc;
      exp_q.push_back(e);
      grant_log.push_back(id);
      n_acc++;
   endtask

   // Consumer ready generator.
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (res_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = ($urandom_range(3, 0) != 0);
            default: bus.res_ready = 1'b0;
         endcase
      end
   end

   // Monitor: scoreboard push on accept, compare on result handshake.
   initial begin
      exp_t        e;
      logic        prev_valid;
      logic [31:0] prev_data;
      logic        prev_id;
      prev_valid = 1'b0;
      prev_data  = 32'd0;
      prev_id    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
         end else begin
            if (bus.req0_valid && bus.req0_ready) record_accept(1'b0);
            if (bus.req1_valid && bus.req1_ready) record_accept(1'b1);
            if (bus.res_valid) begin
               chk("ready_while_res_valid", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
               if (exp_q.size() == 0) begin
                  chk("spurious_result", {31'd0, bus.res_valid}, 32'd0);
               end else if (!prev_valid) begin
                  chk("latency", 32'(cyc - exp_q[0].cyc), 32'(CALC + 1));
               end else begin
                  chk("hold_data_stable", bus.res_data, prev_data);
                  chk("hold_id_stable", {31'd0, bus.res_id}, {31'd0, prev_id});
               end
               if (bus.res_ready && (exp_q.size() != 0)) begin
                  e = exp_q.pop_front();
                  n_res++;
                  tests++;
                  if ((bus.res_data !== e.data) || (bus.res_id !== e.id)) begin
                     fails++;
                     $display("FAIL result: got id=%0d data=%h expected id=%0d data=%h",
                              bus.res_id, bus.res_data, e.id, e.data);
                  end
               end
            end
            prev_valid = bus.res_valid;
            prev_data  = bus.res_data;
            prev_id    = bus.res_id;
         end
      end
   end

   task automatic set_req(input logic id, input logic v, input logic [15:0] a, input logic [15:0] b);
      if (id == 1'b0) begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_valid = v;
      end else begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_valid = v;
      end
   endtask

   // Present one operand pair and hold it until accepted; called at posedge+1.
   task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] expv);
      bit ok;
      ok = 1'b0;
      pend_exp[id] = expv;
      set_req(id, 1'b1, a, b);
      for (int t = 0; (t < TMO) && !ok; t++) begin
         @(negedge clk);
         ok = (id == 1'b0) ? bus.req0_ready : bus.req1_ready;
      end
      @(posedge clk);
      #1;
      set_req(id, 1'b0, a, b);
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: requester %0d got no ready within %0d cycles", id, TMO);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (((exp_q.size() != 0) || bus.busy) && (t < TMO)) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: pending=%0d busy=%0d", exp_q.size(), bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_port(input logic id, input int n);
      logic [15:0] a;
      logic [15:0] b;
      for (int i = 0; i < n; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         send(id, a, b, prod(a, b));
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
      chk({tag, "_res_data"},  bus.res_data, 32'd0);
      chk({tag, "_res_id"},    {31'd0, bus.res_id}, 32'd0);
      chk({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
      chk({tag, "_readys"},    {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
   endtask

   initial begin
      set_req(1'b0, 1'b0, 16'd0, 16'd0);
      set_req(1'b1, 1'b0, 16'd0, 16'd0);
      pend_exp[0] = 32'd0;
      pend_exp[1] = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.req0_valid = 1'b1;
      #1;
      chk_outputs_zero("reset");
`ifdef MULTI_ARB_STATS_EN
      chk("reset_grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
      chk("reset_grant_cnt1", {16'd0, grant_cnt1}, 32'd0);
`endif
      bus.req0_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed products.
      send(1'b0, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
      wait_idle();
      send(1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000);
      wait_idle();
      send(1'b1, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD);
      wait_idle();
      send(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
      wait_idle();

      // Consumer stall in HOLD with both requesters pushing.
      res_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(1'b0, 16'h0002, 16'h0003, 32'd6);
      set_req(1'b0, 1'b1, 16'h0011, 16'h0022);
      set_req(1'b1, 1'b1, 16'h0033, 16'h0044);
      for (int t = 0; (t < TMO) && !bus.res_valid; t++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
         chk("stall_res_data", bus.res_data, 32'd6);
         chk("stall_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b0, 16'd0, 16'd0);
      set_req(1'b1, 1'b0, 16'd0, 16'd0);
      res_mode = 0;
      wait_idle();

      // Reset in the middle of CALC discards the transaction.
      send(1'b1, 16'h0100, 16'h0100, 32'h0001_0000);
      chk("midcalc_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midcalc_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("after_reset_no_result", {31'd0, bus.res_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Both valid held for four results: 0,1,0,1.
      grant_log.delete();
      fork
         begin
            send(1'b0, 16'h0005, 16'hFFFD, 32'hFFFF_FFF1);
            send(1'b0, 16'hFFF0, 16'hFFF0, 32'h0000_0100);
         end
         begin
            send(1'b1, 16'h1234, 16'h0010, 32'h0001_2340);
            send(1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
         end
      join
      wait_idle();
      chk("rr_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         chk("rr_grant0", {31'd0, grant_log[0]}, 32'd0);
         chk("rr_grant1", {31'd0, grant_log[1]}, 32'd1);
         chk("rr_grant2", {31'd0, grant_log[2]}, 32'd0);
         chk("rr_grant3", {31'd0, grant_log[3]}, 32'd1);
      end
      send(1'b0, 16'h0002, 16'h0002, 32'd4);
      wait_idle();
`ifdef MULTI_ARB_STATS_EN
      chk("grant_cnt0", {16'd0, grant_cnt0}, 32'd3);
      chk("grant_cnt1", {16'd0, grant_cnt1}, 32'd2);
`endif

      // Random traffic on both ports with random consumer backpressure.
      n_acc = 0;
      n_res = 0;
      res_mode = 1;
      fork
         rand_port(1'b0, 5000);
         rand_port(1'b1, 5000);
      join
      res_mode = 0;
      wait_idle();
      chk("random_accepted", 32'(n_acc), 32'd10000);
      chk("random_results", 32'(n_res), 32'd10000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
